// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared state encoding and widths for the HI/LO multiply/divide unit
package hilo_pkg;

    localparam int HILO_W     = 32;
    localparam int HILO_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } hilo_state_t;

endpackage

// File: rtl/abs_neg32.sv
// rtl/abs_neg32.sv - conditional two's-complement negate; inc is the carry into the low bit
module abs_neg32
    import hilo_pkg::*;
(
    input  logic [HILO_W-1:0] x,
    input  logic              neg,
    input  logic              inc,
    output logic [HILO_W-1:0] y
);

    assign y = neg ? (~x + {{(HILO_W-1){1'b0}}, inc}) : x;

endmodule

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - 33-cycle iterative signed multiply/divide producing HI/LO
// Optional macro HILO_DIV_ZERO_EXC_EN: trap divide-by-zero at the start edge.
module hilo_muldiv
    import hilo_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start_mult,
    input  logic              start_div,
    input  logic [HILO_W-1:0] a,
    input  logic [HILO_W-1:0] b,
    output logic [HILO_W-1:0] hi_out,
    output logic [HILO_W-1:0] lo_out,
    output logic              busy,
    output logic              done,
    output logic              div_zero
);

    hilo_state_t         state, state_d;
    logic [4:0]          cnt;
    logic [2*HILO_W-1:0] acc;
    logic [HILO_W-1:0]   opm;
    logic                is_div, neg_lo, neg_hi;
    logic [HILO_W-1:0]   mag_a, mag_b, hi_fix, lo_fix;
    logic [HILO_W:0]     mul_sum, div_shift, div_diff;
    logic                div_ge, last, dz_trap, hi_inc;

`ifdef HILO_DIV_ZERO_EXC_EN
    assign dz_trap = (b == '0);
`else
    assign dz_trap = 1'b0;
`endif

    abs_neg32 u_mag_a (.x(a), .neg(a[HILO_W-1]), .inc(1'b1), .y(mag_a));
    abs_neg32 u_mag_b (.x(b), .neg(b[HILO_W-1]), .inc(1'b1), .y(mag_b));

    // 64-bit product negation: the high half only takes the carry when the low half is zero
    assign hi_inc = is_div | (acc[HILO_W-1:0] == '0);
    abs_neg32 u_fix_lo (.x(acc[HILO_W-1:0]), .neg(neg_lo), .inc(1'b1), .y(lo_fix));
    abs_neg32 u_fix_hi (.x(acc[2*HILO_W-1:HILO_W]), .neg(neg_hi), .inc(hi_inc), .y(hi_fix));

    // acc is {partial product, multiplier} for MULT and {remainder, dividend/quotient} for DIV
    assign mul_sum   = {1'b0, acc[2*HILO_W-1:HILO_W]} + (acc[0] ? {1'b0, opm} : '0);
    assign div_shift = {acc[2*HILO_W-1:HILO_W], acc[HILO_W-1]};
    assign div_ge    = (div_shift >= {1'b0, opm});
    assign div_diff  = div_shift - {1'b0, opm};
    assign last      = (cnt == 5'(HILO_ITERS - 1));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (start_mult)                 state_d = MULT;
                else if (start_div && !dz_trap) state_d = DIV;
            end
            MULT, DIV: if (last) state_d = FIX;
            FIX:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            opm    <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            hi_out <= '0;
            lo_out <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start_mult) begin
                        acc    <= {{HILO_W{1'b0}}, mag_b};
                        opm    <= mag_a;
                        is_div <= 1'b0;
                        neg_lo <= a[HILO_W-1] ^ b[HILO_W-1];
                        neg_hi <= a[HILO_W-1] ^ b[HILO_W-1];
                    end else if (start_div && dz_trap) begin
                        done <= 1'b1;
                    end else if (start_div) begin
                        acc    <= {{HILO_W{1'b0}}, mag_a};
                        opm    <= mag_b;
                        is_div <= 1'b1;
                        neg_lo <= a[HILO_W-1] ^ b[HILO_W-1];
                        neg_hi <= a[HILO_W-1];
                    end
                end
                MULT: begin
                    acc <= {mul_sum, acc[HILO_W-1:1]};
                    cnt <= cnt + 5'd1;
                end
                DIV: begin
                    acc <= {(div_ge ? div_diff[HILO_W-1:0] : div_shift[HILO_W-1:0]),
                            acc[HILO_W-2:0], div_ge};
                    cnt <= cnt + 5'd1;
                end
                FIX: begin
                    hi_out <= hi_fix;
                    lo_out <= lo_fix;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef HILO_DIV_ZERO_EXC_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) div_zero <= 1'b0;
        else       div_zero <= (state == IDLE) && !start_mult && start_div && dz_trap;
    end
`else
    assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - directed and random checks of hilo_muldiv against an arithmetic model
module tb_hilo_muldiv;

    logic        clk = 1'b0, reset = 1'b1, start_mult = 1'b0, start_div = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [31:0] hi_out, lo_out;
    logic        busy, done, div_zero;
    int          errors = 0, checks = 0;

    hilo_muldiv dut (
        .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
        .a(a), .b(b), .hi_out(hi_out), .lo_out(lo_out),
        .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic isdiv, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] h, output logic [31:0] l);
        longint sx, sy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!isdiv) begin
            p = sx * sy;
            h = p[63:32];
            l = p[31:0];
        end else if (y == 32'd0) begin
            h = x;
            l = x[31] ? 32'd1 : 32'hFFFF_FFFF;
        end else begin
            p = sx / sy;
            l = p[31:0];
            p = sx % sy;
            h = p[31:0];
        end
    endfunction

    task automatic run_op(input logic m, input logic d, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el, input string tag);
        logic [31:0] ph, pl;
        int          n, bc;
        logic        held;
        @(negedge clk);
        a = x; b = y; start_mult = m; start_div = d;
        @(negedge clk);
        start_mult = 1'b0; start_div = 1'b0;
        ph = hi_out; pl = lo_out;
        n = 0; bc = 0; held = 1'b1;
        while (done !== 1'b1 && n < 40) begin
            if (busy) bc++;
            if (hi_out !== ph || lo_out !== pl) held = 1'b0;
            @(negedge clk);
            n++;
        end
        chk({tag, " done"}, {63'd0, done}, 64'd1);
        chk({tag, " busy_cycles"}, 64'(bc), 64'd33);
        chk({tag, " hold"}, {63'd0, held}, 64'd1);
        chk({tag, " hi"}, {32'd0, hi_out}, {32'd0, eh});
        chk({tag, " lo"}, {32'd0, lo_out}, {32'd0, el});
        chk({tag, " busy_end"}, {63'd0, busy}, 64'd0);
        chk({tag, " div_zero"}, {63'd0, div_zero}, 64'd0);
        @(negedge clk);
        chk({tag, " done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        logic [31:0] x, y, eh, el;
        logic        dv;
        int          n, nd;

        repeat (2) @(negedge clk);
        chk("rst hi", {32'd0, hi_out}, 64'd0);
        chk("rst lo", {32'd0, lo_out}, 64'd0);
        chk("rst busy", {63'd0, busy}, 64'd0);
        chk("rst done", {63'd0, done}, 64'd0);
        chk("rst div_zero", {63'd0, div_zero}, 64'd0);
        reset = 1'b0;

        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mul 7x-3");
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, "mul min^2");
        run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, "mul -1x-1");
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2");
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div ovf");

        run_op(1'b1, 1'b0, 32'd5, 32'd6, 32'd0, 32'd30, "mul 5x6");
`ifdef HILO_DIV_ZERO_EXC_EN
        @(negedge clk);
        a = 32'd100; b = 32'd0; start_div = 1'b1;
        @(negedge clk);
        start_div = 1'b0;
        chk("dz done", {63'd0, done}, 64'd1);
        chk("dz flag", {63'd0, div_zero}, 64'd1);
        chk("dz busy", {63'd0, busy}, 64'd0);
        chk("dz hi", {32'd0, hi_out}, 64'd0);
        chk("dz lo", {32'd0, lo_out}, 64'd30);
        @(negedge clk);
        chk("dz done_pulse", {63'd0, done}, 64'd0);
        chk("dz flag_pulse", {63'd0, div_zero}, 64'd0);
        chk("dz busy_after", {63'd0, busy}, 64'd0);
`else
        run_op(1'b0, 1'b1, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, "div 100/0");
`endif

        // both starts: multiply wins; a start_div at E10 is ignored
        @(negedge clk);
        a = 32'd3; b = 32'd4; start_mult = 1'b1; start_div = 1'b1;
        @(negedge clk);
        start_mult = 1'b0; start_div = 1'b0;
        repeat (9) @(negedge clk);
        a = 32'd50; b = 32'd7; start_div = 1'b1;
        @(negedge clk);
        start_div = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("both done", {63'd0, done}, 64'd1);
        chk("both lo", {32'd0, lo_out}, 64'd12);
        chk("both hi", {32'd0, hi_out}, 64'd0);
        count_dones(40, nd);
        chk("both no_second_done", 64'(nd), 64'd0);

        // asynchronous reset mid-multiply
        @(negedge clk);
        a = 32'd9; b = 32'd9; start_mult = 1'b1;
        @(negedge clk);
        start_mult = 1'b0;
        repeat (14) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst hi", {32'd0, hi_out}, 64'd0);
        chk("arst lo", {32'd0, lo_out}, 64'd0);
        chk("arst busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        count_dones(40, nd);
        chk("arst no_done", 64'(nd), 64'd0);
        run_op(1'b1, 1'b0, 32'd2, 32'd3, 32'd0, 32'd6, "mul 2x3");

        for (int i = 0; i < 20; i++) begin
            dv = 1'($urandom_range(0, 1));
            x  = $urandom;
            y  = $urandom;
            if (i % 4 == 0) y = y >> 28;
            if (i % 5 == 0) x = x >> 20;
            if (dv && y == 32'd0) y = 32'd3;
            model(dv, x, y, eh, el);
            run_op(!dv, dv, x, y, eh, el, dv ? "rand div" : "rand mul");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Iterative signed multiply/divide unit that produces the HI and LO registers consumed by the register-file write-data source multiplexer (its HI and LO inputs). It is started by the control unit for `mult` and `div` and runs for a fixed 33 cycles, holding `busy` while it runs. It pulses `done` when HI/LO are updated, then holds HI/LO until the next operation completes.

## Interface
- No parameters. The operand width is fixed at 32 bits.
- `clk` — in, 1 — system clock; all state changes on the rising edge.
- `reset` — in, 1 — asynchronous, active-high; clears all state.
- `start_mult` — in, 1 — request signed multiply of `a`×`b`; sampled only in IDLE.
- `start_div` — in, 1 — request signed divide `a`/`b`; sampled only in IDLE.
- `a` — in, 32 — multiplicand / dividend; captured at the start edge.
- `b` — in, 32 — multiplier / divisor; captured at the start edge.
- `hi_out` — out, 32 — multiply: product[63:32]; divide: remainder.
- `lo_out` — out, 32 — multiply: product[31:0]; divide: quotient.
- `busy` — out, 1 — high while an operation is in progress.
- `done` — out, 1 — one-cycle pulse after HI/LO are written, or after a divide-by-zero is flagged.
- `div_zero` — out, 1 — one-cycle pulse on divide-by-zero; tied 0 when the macro is absent.

## Operation
- **States:** IDLE, MULT, DIV, FIX.
- **IDLE:**
  - `start_mult` → capture `a` and `b`, iteration counter = 0, go to MULT.
  - Else `start_div` → same capture, go to DIV.
  - Both starts high: multiply wins and the divide request is dropped.
  - Starts outside IDLE are ignored, not queued.
- **MULT:**
  - Unsigned shift-add on operand magnitudes: one multiplier bit per cycle into a 64-bit accumulator.
  - Result sign = sign(a) XOR sign(b).
  - After 32 iterations (counter 31) go to FIX.
- **DIV:**
  - Restoring division on magnitudes: one quotient bit per cycle.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a) (truncation toward zero).
  - After 32 iterations go to FIX.
- **FIX:** apply two's-complement negation where required, write `hi_out`/`lo_out`, assert `done`, go to IDLE.
- **Width rules:**
  - The magnitude of 0x80000000 is 0x80000000, treated as unsigned 33-bit-safe.
  - Divide overflow 0x80000000 / 0xFFFFFFFF yields LO = 0x80000000, HI = 0; no flag.
  - Multiply is exact across the full 64-bit range.
- **Reset:**
  - State → IDLE; `hi_out`, `lo_out` = 0; `busy`, `done`, `div_zero` = 0; internal registers cleared.
  - Reset mid-operation aborts it; no `done` is produced.
- HI/LO change only at the FIX edge (or at reset); intermediate values are never visible on `hi_out`/`lo_out`.

## Timing
- Start sampled at edge E0; `busy` = 1 from E0 until the FIX edge.
- Iterations at edges E1..E32; FIX at edge E33.
- At E33: HI/LO updated, `busy` = 0, `done` = 1 for exactly the cycle after E33.
- Latency from start edge to valid HI/LO: 33 cycles.
- A new start may be sampled in the same cycle `done` is high, i.e. at edge E34. Back-to-back throughput is one operation per 34 cycles.
- `done` and `div_zero` are registered outputs, never combinational from the inputs.

## Configuration
- Macro: `HILO_DIV_ZERO_EXC_EN`.
- **Defined:**
  - `start_div` with `b` == 0 at E0 does not enter DIV and `busy` stays 0.
  - `div_zero` = 1 and `done` = 1 for the cycle after E0.
  - HI/LO keep their prior values.
- **Undefined:**
  - Divide-by-zero runs the normal 33-cycle divide and yields LO = 0xFFFFFFFF when a ≥ 0 (0x00000001 when a < 0) and HI = a.
  - `div_zero` is constant 0.

## Structure
- **Shared package** (`hilo_pkg`) holds:
  - the state encoding (IDLE=2'd0, MULT=2'd1, DIV=2'd2, FIX=2'd3);
  - `HILO_ITERS` = 32;
  - `HILO_W` = 32.
- **One sub-module**, `abs_neg32`: 32-bit conditional two's-complement negate.
  - Used for operand magnitudes at capture and for sign fix-up in FIX.
  - Instanced for each operand and each result half.

## Test plan
- Multiply 7 × 0xFFFFFFFD (−3) → at E33 HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. `busy` is high for exactly 33 cycles and `done` pulses for one.
- Multiply 0x80000000 × 0x80000000 → HI = 0x40000000, LO = 0x00000000. Then 0xFFFFFFFF × 0xFFFFFFFF → HI = 0, LO = 1.
- Divide 0xFFFFFFF9 (−7) / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. Then 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Divide 100 / 0 with HI/LO preloaded by 5 × 6 (LO = 30):
  - with the macro: `div_zero` and `done` pulse the cycle after E0, `busy` never rises, HI = 0 and LO = 30 unchanged;
  - without the macro: after 33 cycles LO = 0xFFFFFFFF, HI = 100.
- Assert `start_mult` and `start_div` together with a = 3, b = 4 → multiply executes: LO = 12, HI = 0. A `start_div` pulse at E10 while busy is ignored and no second `done` appears.
- Assert `reset` asynchronously at E15 of a multiply → outputs go to 0 immediately and no `done` follows. A fresh multiply 2 × 3 afterwards completes normally with LO = 6.
